// File: rtl/param_collector_if.sv
// Response-frame stream from param_collector to the message encoder.
// master drives the frame words; slave applies backpressure through out_ready.
interface param_collector_if;
  logic [32:0] out_data;
  logic        out_hdr;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, out_hdr, out_last, out_valid, input out_ready);
  modport slave  (input out_data, out_hdr, out_last, out_valid, output out_ready);
endinterface

// File: rtl/param_collector.sv
// Buffers a command unit's parameter stream and emits one header+parameters response frame.
// Optional GRANTED-state watchdog is enabled by defining PARAM_COLLECTOR_TIMEOUT_EN.
module param_collector #(
  parameter int MAX_PARAMS     = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [32:0]              param_data,
  input  logic                     param_write,
  input  logic                     cmd_done,
  input  logic                     cmd_active,
  input  logic                     invol_req,
  output logic                     invol_grant,
  output logic                     busy,
  output logic                     overflow,
  output logic                     proto_err,
  output logic                     timeout,
  param_collector_if.master        out_if
);
  localparam int         IDX_W   = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_PARAMS);

  if (MAX_PARAMS < 1 || MAX_PARAMS > 255) begin : g_bad_max_params
    $error("param_collector: MAX_PARAMS must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("param_collector: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, GRANTED, SEND_HDR, SEND_PARAM} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, rd_q, rd_d;
  logic [23:0] code_q, code_d;
  logic [32:0] param_buf [MAX_PARAMS];
  logic        wr_en, grant_d, overflow_d, proto_err_d, tmo_hit;
  logic [32:0] data_d;
  logic        hdr_d, last_d, valid_d;
  logic        hs;

  assign hs = out_if.out_valid && out_if.out_ready;

`ifdef PARAM_COLLECTOR_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_q;

  // The counter sits at zero outside GRANTED, so every entry starts a fresh count.
  assign tmo_hit = (state_q == GRANTED) && (tmo_q == TMO_LAST) && !cmd_done;

  always_ff @(posedge clk) begin
    if (rst || state_q != GRANTED) tmo_q <= '0;
    else                           tmo_q <= tmo_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)          timeout <= 1'b0;
    else if (tmo_hit) timeout <= 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  // NOTE: every signal assigned here gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    code_d      = code_q;
    wr_en       = 1'b0;
    grant_d     = 1'b0;
    overflow_d  = overflow;
    proto_err_d = proto_err;

    unique case (state_q)
      IDLE, GRANTED: begin
        if (param_write) begin
          if (cnt_q != MAX_CNT) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 8'd1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (cmd_done) begin
          // A word arriving with cmd_done is kept, but the response code is unusable.
          proto_err_d = proto_err | param_write;
          code_d      = param_write ? 24'd0 : param_data[23:0];
          state_d     = (cnt_d != 8'd0) ? SEND_HDR : IDLE;
        end else if (tmo_hit) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (state_q == IDLE && invol_req && !cmd_active && cnt_q == 8'd0) begin
          grant_d = 1'b1;
          state_d = GRANTED;
        end
      end
      SEND_HDR, SEND_PARAM: begin
        overflow_d  = overflow | param_write;
        proto_err_d = proto_err | cmd_done;
        if (hs) begin
          if (state_q == SEND_HDR) begin
            rd_d    = 8'd0;
            state_d = SEND_PARAM;
          end else if (rd_q == cnt_q - 8'd1) begin
            rd_d    = 8'd0;
            cnt_d   = 8'd0;
            state_d = IDLE;
          end else begin
            rd_d = rd_q + 8'd1;
          end
        end
      end
      default: ;
    endcase

    // Output words are built from next-state values so the stream is fully registered.
    valid_d = (state_d == SEND_HDR) || (state_d == SEND_PARAM);
    hdr_d   = (state_d == SEND_HDR);
    last_d  = (state_d == SEND_PARAM) && (rd_d == cnt_d - 8'd1);
    data_d  = '0;
    if (state_d == SEND_HDR)        data_d = {1'b0, cnt_d, code_d};
    else if (state_d == SEND_PARAM) data_d = param_buf[rd_d[IDX_W-1:0]];
  end

  // NOTE: the parameter buffer has no reset; cnt alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) param_buf[cnt_q[IDX_W-1:0]] <= param_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= 8'd0;
      rd_q             <= 8'd0;
      code_q           <= 24'd0;
      invol_grant      <= 1'b0;
      busy             <= 1'b0;
      overflow         <= 1'b0;
      proto_err        <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_hdr   <= 1'b0;
      out_if.out_last  <= 1'b0;
      out_if.out_valid <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      rd_q             <= rd_d;
      code_q           <= code_d;
      invol_grant      <= grant_d;
      busy             <= (state_d != IDLE);
      overflow         <= overflow_d;
      proto_err        <= proto_err_d;
      out_if.out_data  <= data_d;
      out_if.out_hdr   <= hdr_d;
      out_if.out_last  <= last_d;
      out_if.out_valid <= valid_d;
    end
  end
endmodule
